sub_bytes_serial: RTL and testbench

Parametrised, area-scalable SubBytes / InvSubBytes engine for the low-area AES datapath. It accepts an NBYTES-wide state word over a valid/ready handshake and pushes it through LANES shared `bSbox` instances. Each cycle it substitutes LANES bytes, so a full word takes NBYTES/LANES cycles. Latency can be traded against S-box count without touching the round controller, and the direction (forward or inverse) is selected per word.

---
 rtl/sub_bytes_serial.sv | 177 +++++++++++++++++
 tb/tb_sub_bytes_serial.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// Serial SubBytes/InvSubBytes engine: LANES shared S-boxes process an NBYTES word
// over NBYTES/LANES beats, with an optional register stage after the S-boxes.

module b_sbox (
    input  logic       encrypt,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    logic [7:0] t;

    always_comb begin
        t    = 8'h00;
        dout = 8'h00;
        if (encrypt) begin
            t    = gf_inv(din);
            dout = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
        end else begin
            t    = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
            dout = gf_inv(t);
        end
    end
endmodule

module sub_bytes_serial #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4,
    parameter int PIPE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  encrypt,
    input  logic [8*NBYTES-1:0]   data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  busy
);
    localparam int K  = NBYTES / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if (NBYTES < 1 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_params
            $error("sub_bytes_serial: LANES must divide NBYTES");
        end
    endgenerate

    // state | meaning
    // IDLE  | waiting for a word, in_ready=1
    // BUSY  | substituting LANES bytes per beat
    // DRAIN | PIPE=1 only: writes the last pipe-register group
    // DONE  | result valid, waiting for out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         beat_q;
    logic                  mode_q;
    logic [8*NBYTES-1:0]   src_q;
    logic [8*NBYTES-1:0]   res_q;
    logic [8*LANES-1:0]    pipe_q;
    logic [8*LANES-1:0]    sb_in;
    logic [8*LANES-1:0]    sb_out;
    logic [8*LANES-1:0]    wr_data;
    logic                  wr_en;
    int                    rd_base;
    int                    wr_base;

    always_comb begin
        rd_base = int'(beat_q) * LANES;
        sb_in   = '0;
        for (int l = 0; l < LANES; l++) sb_in[l*8 +: 8] = src_q[(rd_base + l)*8 +: 8];
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            b_sbox u_sbox (
                .encrypt (mode_q),
                .din     (sb_in[g*8 +: 8]),
                .dout    (sb_out[g*8 +: 8])
            );
        end
    endgenerate

    // With the pipe stage the result write trails the S-box read by one beat,
    // so beat 0 writes nothing and DRAIN (beat_q held at K-1) writes the last group.
    always_comb begin
        wr_en   = 1'b0;
        wr_base = rd_base;
        wr_data = sb_out;
        if (PIPE == 0) begin
            wr_en = (state_q == BUSY);
        end else begin
            wr_data = pipe_q;
            if (state_q == BUSY) begin
                wr_en   = (beat_q != '0);
                wr_base = rd_base - LANES;
            end else if (state_q == DRAIN) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mode_q  <= 1'b1;
            src_q   <= '0;
            res_q   <= '0;
            pipe_q  <= '0;
        end else begin
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) res_q[(wr_base + l)*8 +: 8] <= wr_data[l*8 +: 8];
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q   <= data_in;
                        mode_q  <= encrypt;
                        beat_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    pipe_q <= sb_out;
                    if (beat_q == LAST) state_q <= (PIPE != 0) ? DRAIN : DONE;
                    else                beat_q  <= beat_q + 1'b1;
                end
                DRAIN: state_q <= DONE;
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY) || (state_q == DRAIN);
    assign data_out  = res_q;
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial: default build plus a LANES=2, PIPE=1 build,
// checked against a table-driven AES S-box model through an expected-word queue.

module tb_sub_bytes_serial;
    logic         clk;
    logic         rst_n;

    logic         in_valid, in_ready, encrypt, out_valid, out_ready, busy;
    logic [127:0] data_in, data_out;
    logic         p_in_valid, p_in_ready, p_encrypt, p_out_valid, p_out_ready, p_busy;
    logic [127:0] p_data_in, p_data_out;

    int total;
    int bad;

    logic [127:0] sb_q[$];
    logic [7:0]   fwd[256];
    logic [7:0]   inv[256];
    logic [127:0] fwd_rows[16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    sub_bytes_serial #(.NBYTES(16), .LANES(4), .PIPE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .encrypt(encrypt), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    sub_bytes_serial #(.NBYTES(16), .LANES(2), .PIPE(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .encrypt(p_encrypt), .data_in(p_data_in), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .data_out(p_data_out), .busy(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [127:0] d, input logic e);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = e ? fwd[d[8*i +: 8]] : inv[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? p_in_ready : in_ready;
    endfunction
    function automatic logic ov(input bit sel);
        return sel ? p_out_valid : out_valid;
    endfunction
    function automatic logic [127:0] dout(input bit sel);
        return sel ? p_data_out : data_out;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [127:0] d, input logic e);
        if (sel) begin p_in_valid = v; p_data_in = d; p_encrypt = e; end
        else     begin in_valid = v;   data_in = d;   encrypt = e;   end
    endtask

    task automatic set_ordy(input bit sel, input logic v);
        if (sel) p_out_ready = v;
        else     out_ready = v;
    endtask

    // Returns at the falling edge just after the accept edge; in_valid keeps its value.
    task automatic accept(input bit sel, input logic [127:0] d, input logic e, input string tag);
        int n;
        set_in(sel, 1'b1, d, e);
        sb_q.push_back(model(d, e));
        n = 0;
        while (!rdy(sel) && n < 100) begin @(negedge clk); n++; end
        check({tag, "_in_ready"}, 128'(rdy(sel)), 128'd1);
        @(negedge clk);
    endtask

    task automatic wait_out(input bit sel, input int exp_lat, input bit tog, input string tag);
        int lat;
        logic [127:0] exp;
        lat = 0;
        while (!ov(sel) && lat < 100) begin
            if (tog) begin
                if (sel) p_encrypt = ~p_encrypt;
                else     encrypt = ~encrypt;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        if (sb_q.size() == 0) begin
            check({tag, "_queue_empty"}, 128'd1, 128'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_data"}, dout(sel), exp);
        end
    endtask

    task automatic release_out(input bit sel, input string tag);
        set_ordy(sel, 1'b1);
        @(negedge clk);
        set_ordy(sel, 1'b0);
        check({tag, "_ov_low"}, 128'(ov(sel)), 128'd0);
        check({tag, "_rdy_high"}, 128'(rdy(sel)), 128'd1);
    endtask

    initial begin
        logic [127:0] w;
        logic [127:0] fips_in;
        logic [127:0] fips_out;
        logic [127:0] exp_w;

        total = 0;
        bad   = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) fwd[r*16 + c] = fwd_rows[r][8*(15-c) +: 8];
        for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);

        fips_in  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
        fips_out = 128'h3052411ee55db4b8f198bfe0ae1127d4;

        rst_n = 1'b0;
        set_in(0, 1'b0, '0, 1'b1);
        set_in(1, 1'b0, '0, 1'b1);
        out_ready = 1'b0;
        p_out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        check("rst_p_in_ready", 128'(p_in_ready), 128'd1);
        check("rst_p_data_out", p_data_out, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward FIPS-197 round-1 vector on the default build
        check("fips_model", model(fips_in, 1'b1), fips_out);
        accept(0, fips_in, 1'b1, "fips");
        set_in(0, 1'b0, '0, 1'b1);
        check("fips_busy", 128'(busy), 128'd1);
        wait_out(0, 4, 1'b0, "fips");
        release_out(0, "fips");

        // Inverse on the pipelined build while encrypt toggles every cycle
        accept(1, fips_out, 1'b0, "pinv");
        wait_out(1, 9, 1'b1, "pinv");
        set_in(1, 1'b0, '0, 1'b1);
        check("pinv_orig", p_data_out, fips_in);
        release_out(1, "pinv");

        // Every byte value, forward then inverse
        for (int e = 1; e >= 0; e--) begin
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16*j + i);
                accept(0, w, 1'(e), e ? "swf" : "swi");
                set_in(0, 1'b0, '0, 1'b1);
                wait_out(0, 4, 1'b0, e ? "swf" : "swi");
                release_out(0, e ? "swf" : "swi");
            end
        end

        // Backpressure with in_valid held high
        accept(0, fips_in, 1'b1, "bp1");
        exp_w = model(fips_in, 1'b1);
        set_in(0, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0);
        wait_out(0, 4, 1'b0, "bp1");
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_hold_data", data_out, exp_w);
            check("bp_hold_rdy", 128'(in_ready), 128'd0);
            check("bp_hold_ov", 128'(out_valid), 128'd1);
        end
        sb_q.push_back(model(128'h00112233445566778899aabbccddeeff, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel_ov", 128'(out_valid), 128'd0);
        check("bp_rel_rdy", 128'(in_ready), 128'd1);
        check("bp_rel_busy", 128'(busy), 128'd0);
        @(negedge clk);
        set_in(0, 1'b0, '0, 1'b1);
        check("bp2_busy", 128'(busy), 128'd1);
        check("bp2_rdy", 128'(in_ready), 128'd0);
        wait_out(0, 4, 1'b0, "bp2");
        release_out(0, "bp2");

        // Asynchronous reset during beat 2
        accept(0, fips_in, 1'b1, "mid");
        set_in(0, 1'b0, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_ov", 128'(out_valid), 128'd0);
        check("mid_busy", 128'(busy), 128'd0);
        check("mid_data", data_out, 128'd0);
        check("mid_rdy", 128'(in_ready), 128'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(0, 128'd0, 1'b1, "post");
        set_in(0, 1'b0, '0, 1'b1);
        wait_out(0, 4, 1'b0, "post");
        check("post_all63", data_out, {16{8'h63}});
        release_out(0, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
